// File: rtl/act_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
//  Shared definitions for the piecewise-linear activation datapath:
//  mode encodings, segment codes, and the fixed-point breakpoints/offsets
//  expressed as functions of the fraction width (and guard bits for offsets).
// ---------------------------------------------------------------------------
package act_pkg;

   typedef enum logic [1:0] {
      ACT_PLAN = 2'd0,   // PLAN sigmoid
      ACT_HARD = 2'd1,   // hard sigmoid
      ACT_TANH = 2'd2,   // tanh via 2*sigmoid(2x)-1
      ACT_RELU = 2'd3    // clamped ReLU
   } act_mode_e;

   // SEG_SAT doubles as the saturation marker for every mode.
   typedef enum logic [1:0] {
      SEG_LIN0 = 2'd0,
      SEG_LIN1 = 2'd1,
      SEG_LIN2 = 2'd2,
      SEG_SAT  = 2'd3
   } act_seg_e;

   // num / 2^den_log2 expressed with 'frac' fraction bits
   function automatic int unsigned q_const(input int unsigned num,
                                           input int unsigned den_log2,
                                           input int unsigned frac);
      return num << (frac - den_log2);
   endfunction

   // Breakpoints at input scale (FRAC_W fraction bits)
   function automatic int unsigned bp_lin1(input int unsigned f); return q_const(1, 0, f);  endfunction // 1.0
   function automatic int unsigned bp_lin2(input int unsigned f); return q_const(19, 3, f); endfunction // 2.375
   function automatic int unsigned bp_sat (input int unsigned f); return q_const(5, 0, f);  endfunction // 5.0
   function automatic int unsigned bp_hard(input int unsigned f); return q_const(2, 0, f);  endfunction // 2.0

   // Offsets and unity at internal scale (FRAC_W+GUARD_W fraction bits)
   function automatic int unsigned off_lin0(input int unsigned f, input int unsigned g); return q_const(1, 1, f+g);  endfunction // .5
   function automatic int unsigned off_lin1(input int unsigned f, input int unsigned g); return q_const(5, 3, f+g);  endfunction // .625
   function automatic int unsigned off_lin2(input int unsigned f, input int unsigned g); return q_const(27, 5, f+g); endfunction // .84375
   function automatic int unsigned q_one   (input int unsigned fg);                      return q_const(1, 0, fg);   endfunction

endpackage

// File: rtl/pwl_segment_eval.sv
// ---------------------------------------------------------------------------
// pwl_segment_eval
//  Combinational slope/offset evaluator for the middle pipeline stage.
//  Produces the positive-half sigmoid value (or clamped ReLU value) with
//  GUARD_W extra fraction bits; reflection for negative inputs happens later.
//  abs_x : |x| magnitude, FRAC_W fraction bits
//  neg   : sign of the operand
//  seg   : segment from the classifier (SEG_SAT = saturated region)
//  mode  : activation mode of this beat
//  y     : unsigned result, FRAC_W+GUARD_W fraction bits
// ---------------------------------------------------------------------------
module pwl_segment_eval
   import act_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                FRAC_W   = 8,
   parameter int                GUARD_W  = 5,
   parameter logic [DATA_W-1:0] RELU_MAX = 16'h0600
) (
   input  logic [DATA_W-2:0]         abs_x,
   input  logic                      neg,
   input  act_seg_e                  seg,
   input  act_mode_e                 mode,
   output logic [DATA_W+GUARD_W-1:0] y
);

   localparam int YW = DATA_W + GUARD_W;
   localparam int FG = FRAC_W + GUARD_W;

   localparam logic [YW-1:0] ONE  = YW'(q_one(FG));
   localparam logic [YW-1:0] OFF0 = YW'(off_lin0(FRAC_W, GUARD_W));
   localparam logic [YW-1:0] OFF1 = YW'(off_lin1(FRAC_W, GUARD_W));
   localparam logic [YW-1:0] OFF2 = YW'(off_lin2(FRAC_W, GUARD_W));

   logic [YW-1:0] ax_g;   // |x| rescaled to the internal fraction width
   assign ax_g = {1'b0, abs_x, {GUARD_W{1'b0}}};

   always_comb begin
      y = ONE;
      if (mode == ACT_RELU) begin
         if (seg == SEG_SAT)
            y = {RELU_MAX, {GUARD_W{1'b0}}};
         else if (neg)
            y = '0;
         else
            y = ax_g;
      end else if (mode == ACT_HARD) begin
         if (seg != SEG_SAT)
            y = (ax_g >> 2) + OFF0;
      end else begin
         // PLAN sigmoid; tanh shares it on the pre-scaled operand
         case (seg)
            SEG_LIN0: y = (ax_g >> 2) + OFF0;
            SEG_LIN1: y = (ax_g >> 3) + OFF1;
            SEG_LIN2: y = (ax_g >> 5) + OFF2;
            default:  y = ONE;
         endcase
      end
   end

endmodule

// File: rtl/pwl_activation_pipe.sv
// ---------------------------------------------------------------------------
// pwl_activation_pipe
//  Three-stage piecewise-linear activation unit with valid/ready flow control.
//   S1: tanh pre-scale, |x|/sign, segment classification
//   S2: slope/offset evaluation (pwl_segment_eval)
//   S3: negative reflection, tanh remap, half-up rounding, output clamp
//  Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid/in_ready     input handshake; in_data (signed Q), in_mode
//   out_valid/out_ready   output handshake; out_data (signed Q), sat_flag
// ---------------------------------------------------------------------------
module pwl_activation_pipe
   import act_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                FRAC_W   = 8,
   parameter int                GUARD_W  = 5,
   parameter logic [DATA_W-1:0] RELU_MAX = 16'h0600
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              sat_flag
);

   localparam int AW = DATA_W - 1;          // magnitude width
   localparam int YW = DATA_W + GUARD_W;    // internal unsigned result width
   localparam int TW = YW + 2;              // signed S3 work width
   localparam int FG = FRAC_W + GUARD_W;

   localparam logic [DATA_W-1:0] X_MIN = {1'b1, {AW{1'b0}}};
   localparam logic [DATA_W-1:0] X_MAX = {1'b0, {AW{1'b1}}};

   localparam logic [AW-1:0] BP_LIN1 = AW'(bp_lin1(FRAC_W));
   localparam logic [AW-1:0] BP_LIN2 = AW'(bp_lin2(FRAC_W));
   localparam logic [AW-1:0] BP_SAT  = AW'(bp_sat(FRAC_W));
   localparam logic [AW-1:0] BP_HARD = AW'(bp_hard(FRAC_W));

   localparam logic signed [TW-1:0] ONE_T   = TW'(q_one(FG));
   localparam logic signed [TW-1:0] RND_T   = TW'(q_one(GUARD_W - 1));
   localparam logic signed [TW-1:0] ONE_O   = TW'(q_one(FRAC_W));
   localparam logic signed [TW-1:0] NEG_O   = -ONE_O;
   localparam logic signed [TW-1:0] ZERO_T  = '0;

   // ---------------- handshake ----------------
   // Each stage loads when empty or when the stage after it loads, so
   // bubbles collapse and a full pipe can accept and drain in one cycle.
   logic [3:1] vld_pipe;
   logic       en1, en2, en3;

   assign en3       = !vld_pipe[3] || out_ready;
   assign en2       = !vld_pipe[2] || en3;
   assign en1       = !vld_pipe[1] || en2;
   assign in_ready  = en1;
   assign out_valid = vld_pipe[3];

   // ---------------- S1 combinational ----------------
   act_mode_e         mode_in;
   logic [DATA_W-1:0] x2, op;
   logic              op_neg;
   logic [AW-1:0]     op_abs;
   act_seg_e          seg_in;

   assign mode_in = act_mode_e'(in_mode);

   always_comb begin
      // x<<1 saturates when the two top bits differ
      x2 = {in_data[DATA_W-2:0], 1'b0};
      if (in_data[DATA_W-1] != in_data[DATA_W-2])
         x2 = in_data[DATA_W-1] ? X_MIN : X_MAX;
      op     = (mode_in == ACT_TANH) ? x2 : in_data;
      op_neg = op[DATA_W-1];
      // negating the low bits gives |op| except for the most negative value
      if (!op_neg)
         op_abs = op[AW-1:0];
      else if (op == X_MIN)
         op_abs = X_MAX[AW-1:0];
      else
         op_abs = (~op[AW-1:0]) + AW'(1);

      seg_in = SEG_LIN0;
      if (mode_in == ACT_RELU) begin
         if (!op_neg && ({1'b0, op_abs} > RELU_MAX)) seg_in = SEG_SAT;
      end else if (mode_in == ACT_HARD) begin
         if (op_abs >= BP_HARD) seg_in = SEG_SAT;
      end else begin
         if (op_abs >= BP_SAT)       seg_in = SEG_SAT;
         else if (op_abs >= BP_LIN2) seg_in = SEG_LIN2;
         else if (op_abs >= BP_LIN1) seg_in = SEG_LIN1;
      end
   end

   // ---------------- stage registers ----------------
   logic [AW-1:0]  s1_abs;
   logic           s1_neg;
   act_seg_e       s1_seg;
   act_mode_e      s1_mode;

   logic [YW-1:0]  s2_y;
   logic           s2_neg, s2_sat;
   act_mode_e      s2_mode;
   logic [YW-1:0]  y_eval;

   pwl_segment_eval #(
      .DATA_W   (DATA_W),
      .FRAC_W   (FRAC_W),
      .GUARD_W  (GUARD_W),
      .RELU_MAX (RELU_MAX)
   ) u_eval (
      .abs_x (s1_abs),
      .neg   (s1_neg),
      .seg   (s1_seg),
      .mode  (s1_mode),
      .y     (y_eval)
   );

   // ---------------- S3 combinational ----------------
   logic signed [TW-1:0] t, r;
   logic [DATA_W-1:0]    s3_d;

   always_comb begin
      t = signed'({2'b00, s2_y});
      if (s2_mode != ACT_RELU && s2_neg)
         t = ONE_T - t;                   // sigmoid(-x) = 1 - sigmoid(x)
      if (s2_mode == ACT_TANH)
         t = (t <<< 1) - ONE_T;           // tanh(x) = 2*sigmoid(2x) - 1
      r = (t + RND_T) >>> GUARD_W;        // round half-up
      if (s2_mode != ACT_RELU) begin
         if (r > ONE_O) r = ONE_O;
         if (s2_mode == ACT_TANH) begin
            if (r < NEG_O) r = NEG_O;
         end else if (r < ZERO_T) begin
            r = ZERO_T;
         end
      end
      s3_d = r[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         s1_abs   <= '0;
         s1_neg   <= 1'b0;
         s1_seg   <= SEG_LIN0;
         s1_mode  <= ACT_PLAN;
         s2_y     <= '0;
         s2_neg   <= 1'b0;
         s2_sat   <= 1'b0;
         s2_mode  <= ACT_PLAN;
         out_data <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (en1) vld_pipe[1] <= in_valid;
         if (en2) vld_pipe[2] <= vld_pipe[1];
         if (en3) vld_pipe[3] <= vld_pipe[2];
         if (en1 && in_valid) begin
            s1_abs  <= op_abs;
            s1_neg  <= op_neg;
            s1_seg  <= seg_in;
            s1_mode <= mode_in;
         end
         if (en2 && vld_pipe[1]) begin
            s2_y    <= y_eval;
            s2_neg  <= s1_neg;
            s2_sat  <= (s1_seg == SEG_SAT);
            s2_mode <= s1_mode;
         end
         if (en3 && vld_pipe[2]) begin
            out_data <= s3_d;
            sat_flag <= s2_sat;
         end
      end
   end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// ---------------------------------------------------------------------------
// tb_pwl_activation_pipe
//  Directed vector table for every mode plus stall, full-pipe and reset
//  sequences. DATA_W=16, FRAC_W=8, GUARD_W=5, RELU_MAX=6.0.
// ---------------------------------------------------------------------------
module tb_pwl_activation_pipe;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [1:0]  in_mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        sat_flag;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pwl_activation_pipe #(
      .DATA_W   (16),
      .FRAC_W   (8),
      .GUARD_W  (5),
      .RELU_MAX (16'h0600)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_flag  (sat_flag)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] x;
      logic [15:0] y;
      logic        sat;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic [1:0] m, input logic [15:0] x,
                               input logic [15:0] y, input logic s);
      vec_t v;
      v.mode = m; v.x = x; v.y = y; v.sat = s;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one isolated beat: checks accept, 3-cycle latency, data and sat
   task automatic run_one(input vec_t v, input int k);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_mode = v.mode; in_data = v.x;
      #1 chk($sformatf("v%0d in_ready", k), in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("v%0d latency", k), n, 3);
      chk($sformatf("v%0d m%0d x=%h data", k, v.mode, v.x), out_data, v.y);
      chk($sformatf("v%0d m%0d x=%h sat", k, v.mode, v.x), sat_flag, v.sat);
   endtask

   initial begin
      int sidx[8] = '{1, 13, 21, 29, 3, 15, 27, 31};
      int ii, oi, extra;
      logic held_v, acc, drn;
      logic [15:0] held_d;

      // ---- vector table (hand computed) ----
      // PLAN sigmoid
      tv.push_back(mk(0, 16'h0000, 16'h0080, 0));
      tv.push_back(mk(0, 16'h0100, 16'h00C0, 0));
      tv.push_back(mk(0, 16'hFF00, 16'h0040, 0));
      tv.push_back(mk(0, 16'h0600, 16'h0100, 1));
      tv.push_back(mk(0, 16'hFA00, 16'h0000, 1));
      tv.push_back(mk(0, 16'h0002, 16'h0081, 0));   // 128.5 rounds up
      tv.push_back(mk(0, 16'hFFFE, 16'h0080, 0));   // 127.5 rounds up
      tv.push_back(mk(0, 16'h0260, 16'h00EB, 0));   // 2.375 uses 1/32 slope
      tv.push_back(mk(0, 16'h025F, 16'h00EC, 0));   // just below uses 1/8
      tv.push_back(mk(0, 16'h0500, 16'h0100, 1));   // 5.0 saturates
      tv.push_back(mk(0, 16'h04FF, 16'h0100, 0));   // rounds to 1, not saturated
      tv.push_back(mk(0, 16'h8000, 16'h0000, 1));
      tv.push_back(mk(0, 16'hFD00, 16'h0010, 0));
      // hard sigmoid
      tv.push_back(mk(1, 16'h0100, 16'h00C0, 0));
      tv.push_back(mk(1, 16'h0300, 16'h0100, 1));
      tv.push_back(mk(1, 16'h8000, 16'h0000, 1));
      tv.push_back(mk(1, 16'h0200, 16'h0100, 1));
      tv.push_back(mk(1, 16'h01FF, 16'h0100, 0));
      tv.push_back(mk(1, 16'hFE00, 16'h0000, 1));
      tv.push_back(mk(1, 16'hFF00, 16'h0040, 0));
      // tanh
      tv.push_back(mk(2, 16'h0100, 16'h00C0, 0));
      tv.push_back(mk(2, 16'hFF00, 16'hFF40, 0));
      tv.push_back(mk(2, 16'h0000, 16'h0000, 0));
      tv.push_back(mk(2, 16'h0001, 16'h0001, 0));
      tv.push_back(mk(2, 16'hFFFF, 16'hFFFF, 0));
      tv.push_back(mk(2, 16'h0280, 16'h0100, 1));
      tv.push_back(mk(2, 16'h8000, 16'hFF00, 1));
      tv.push_back(mk(2, 16'h7FFF, 16'h0100, 1));
      tv.push_back(mk(2, 16'h027F, 16'h0100, 0));
      // clamped ReLU
      tv.push_back(mk(3, 16'hFD00, 16'h0000, 0));
      tv.push_back(mk(3, 16'h0280, 16'h0280, 0));
      tv.push_back(mk(3, 16'h0700, 16'h0600, 1));
      tv.push_back(mk(3, 16'h0600, 16'h0600, 0));
      tv.push_back(mk(3, 16'h8000, 16'h0000, 0));
      tv.push_back(mk(3, 16'h7FFF, 16'h0600, 1));
      tv.push_back(mk(3, 16'h0001, 16'h0001, 0));

      // ---- reset state ----
      #12;
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset out_data", out_data, 0);
      chk("reset sat_flag", sat_flag, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // ---- isolated beats ----
      for (int k = 0; k < tv.size(); k++) run_one(tv[k], k);

      // ---- back-to-back mixed modes with out_ready low in cycles 3..6 ----
      ii = 0; oi = 0; held_v = 1'b0; held_d = '0;
      for (int c = 0; c < 60 && oi < 8; c++) begin
         @(negedge clk);
         out_ready = !(c >= 3 && c <= 6);
         in_valid  = (ii < 8);
         if (ii < 8) begin
            in_mode = tv[sidx[ii]].mode;
            in_data = tv[sidx[ii]].x;
         end
         #1;
         if (held_v) begin
            chk($sformatf("stream c%0d hold valid", c), out_valid, 1);
            chk($sformatf("stream c%0d hold data", c), out_data, held_d);
         end
         if (c >= 3 && c <= 6)
            chk($sformatf("stream c%0d stalled in_ready", c), in_ready, 0);
         acc = in_valid && in_ready;
         drn = out_valid && out_ready;
         if (drn) begin
            chk($sformatf("stream out%0d data", oi), out_data, tv[sidx[oi]].y);
            chk($sformatf("stream out%0d sat", oi), sat_flag, tv[sidx[oi]].sat);
            oi++;
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
         @(posedge clk);
         if (acc) ii++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream accepted", ii, 8);
      chk("stream delivered", oi, 8);
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      chk("stream no duplicate", extra, 0);

      // ---- reset with three beats in flight ----
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_mode = tv[k].mode; in_data = tv[k].x;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("inflight out_valid before reset", out_valid, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async reset out_valid", out_valid, 0);
      chk("async reset out_data", out_data, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("in_ready after release", in_ready, 1);
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      chk("no output after reset", extra, 0);
      run_one(tv[20], 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
